// File: rtl/bram_port_a_arbiter.sv
// bram_port_a_arbiter
// Shares port A of a byte-write, write-first true-dual-port RAM between two
// requesters (R0, R1). Round-robin arbitration with a bounded burst lock;
// read responses are routed back to the issuing requester after the RAM's
// 2-cycle registered read latency. Port B of the RAM is not touched.
// Optional build macro: BRAM_ARB_PERF_CNT_EN adds saturating grant/conflict
// counters (perf_grant0_o, perf_grant1_o, perf_conflict_o).
module bram_port_a_arbiter #(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 9,
  parameter int ADDR_W    = 10,
  parameter int MAX_LOCK  = 8
) (
  input  logic                          clka,
  input  logic                          rstb,
  // requester 0
  input  logic                          r0_valid_i,
  output logic                          r0_ready_o,
  input  logic                          r0_lock_i,
  input  logic [NB_COL-1:0]             r0_we_i,
  input  logic [ADDR_W-1:0]             r0_addr_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   r0_wdata_i,
  output logic                          r0_rvalid_o,
  output logic [NB_COL*COL_WIDTH-1:0]   r0_rdata_o,
  // requester 1
  input  logic                          r1_valid_i,
  output logic                          r1_ready_o,
  input  logic                          r1_lock_i,
  input  logic [NB_COL-1:0]             r1_we_i,
  input  logic [ADDR_W-1:0]             r1_addr_i,
  input  logic [NB_COL*COL_WIDTH-1:0]   r1_wdata_i,
  output logic                          r1_rvalid_o,
  output logic [NB_COL*COL_WIDTH-1:0]   r1_rdata_o,
  // RAM port A
  output logic                          ram_ena_o,
  output logic [NB_COL-1:0]             ram_wea_o,
  output logic [ADDR_W-1:0]             ram_addra_o,
  output logic [NB_COL*COL_WIDTH-1:0]   ram_dina_o,
  output logic                          ram_regcea_o,
  output logic                          ram_rsta_o,
  input  logic [NB_COL*COL_WIDTH-1:0]   ram_douta_i
`ifdef BRAM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_grant0_o,
  output logic [31:0]                   perf_grant1_o,
  output logic [31:0]                   perf_conflict_o
`endif
);

  localparam int DW = NB_COL * COL_WIDTH;
  // Wide enough to hold MAX_LOCK-1 even when MAX_LOCK is 1.
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rr_last_q, rr_last_d;   // last granted requester
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic gnt0, gnt1;
  logic rd_issue;

  // Read tracking: stage [0] captured at the issue edge, stage [1] lines up
  // with the RAM output register; tag 1 means the read belongs to R1.
  logic [1:0] vld_pipe_q;
  logic [1:0] tag_pipe_q;

  // ---------------------------------------------------------------------
  // FSM state register
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q    <= ARB;
      rr_last_q  <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next state: round-robin pointer follows every grant, lock bookkeeping
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    lock_cnt_d = lock_cnt_q;
    if (gnt0)      rr_last_d = 1'b0;
    else if (gnt1) rr_last_d = 1'b1;
    unique case (state_q)
      ARB: begin
        if (MAX_LOCK > 1) begin
          if (gnt0 && r0_lock_i) begin
            state_d    = LOCK0;
            lock_cnt_d = CW'(1);
          end else if (gnt1 && r1_lock_i) begin
            state_d    = LOCK1;
            lock_cnt_d = CW'(1);
          end
        end
      end
      LOCK0: begin
        // leave on idle, on an unlocked grant, or when the burst budget runs out
        if (!gnt0 || !r0_lock_i || lock_cnt_q >= LOCK_LAST) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      LOCK1: begin
        if (!gnt1 || !r1_lock_i || lock_cnt_q >= LOCK_LAST) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Grant decode: combinational from state and valids, never during reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rstb) begin
      unique case (state_q)
        ARB: begin
          if (r0_valid_i && r1_valid_i) begin
            gnt0 = rr_last_q;
            gnt1 = ~rr_last_q;
          end else begin
            gnt0 = r0_valid_i;
            gnt1 = r1_valid_i;
          end
        end
        LOCK0:   gnt0 = r0_valid_i;
        LOCK1:   gnt1 = r1_valid_i;
        default: ;
      endcase
    end
  end

  assign r0_ready_o = gnt0;
  assign r1_ready_o = gnt1;

  // ---------------------------------------------------------------------
  // RAM port A drive: granted requester's fields, zero when idle
  always_comb begin
    ram_wea_o   = '0;
    ram_addra_o = '0;
    ram_dina_o  = '0;
    if (gnt0) begin
      ram_wea_o   = r0_we_i;
      ram_addra_o = r0_addr_i;
      ram_dina_o  = r0_wdata_i;
    end else if (gnt1) begin
      ram_wea_o   = r1_we_i;
      ram_addra_o = r1_addr_i;
      ram_dina_o  = r1_wdata_i;
    end
  end

  assign ram_ena_o    = gnt0 | gnt1;
  assign ram_regcea_o = 1'b1;
  assign ram_rsta_o   = rstb;

  // A transfer with no byte enables is a read.
  assign rd_issue = ram_ena_o & ~(|ram_wea_o);

  // Read valid/tag pipeline; reset drops anything in flight
  always_ff @(posedge clka) begin
    if (rstb) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], rd_issue};
      tag_pipe_q <= {tag_pipe_q[0], gnt1};
    end
  end

  // Response routing; write-first data on douta never raises rvalid
  always_comb begin
    r0_rvalid_o = vld_pipe_q[1] & ~tag_pipe_q[1] & ~rstb;
    r1_rvalid_o = vld_pipe_q[1] &  tag_pipe_q[1] & ~rstb;
  end

  assign r0_rdata_o = ram_douta_i[DW-1:0];
  assign r1_rdata_o = ram_douta_i[DW-1:0];

`ifdef BRAM_ARB_PERF_CNT_EN
  // ---------------------------------------------------------------------
  logic conflict;
  assign conflict = (r0_valid_i & ~gnt0) | (r1_valid_i & ~gnt1);

  // Saturating performance counters
  always_ff @(posedge clka) begin
    if (rstb) begin
      perf_grant0_o   <= '0;
      perf_grant1_o   <= '0;
      perf_conflict_o <= '0;
    end else begin
      if (gnt0 && perf_grant0_o != 32'hFFFF_FFFF)
        perf_grant0_o <= perf_grant0_o + 32'd1;
      if (gnt1 && perf_grant1_o != 32'hFFFF_FFFF)
        perf_grant1_o <= perf_grant1_o + 32'd1;
      if (conflict && perf_conflict_o != 32'hFFFF_FFFF)
        perf_conflict_o <= perf_conflict_o + 32'd1;
    end
  end
`endif

endmodule
